// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid/ready handshake, optional two-entry skid
// buffer, flush, cache-miss freeze and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4,
  parameter int CTRL_W   = 10,
  parameter int TAG_W    = 16,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hit,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W*NUM_DATA-1:0] in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W*NUM_DATA-1:0] out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [TAG_W-1:0]           out_tag,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int DN_W  = DATA_W * NUM_DATA;
  localparam int PAY_W = DN_W + CTRL_W + TAG_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state, stateNext;
  logic [PAY_W-1:0]   inPay, mainPay, skidPay;
  logic               acc, take, bubble;
  logic               loadMainIn, loadMainSkid, loadSkid;
  logic [CNT_W-1:0]   bubbleCnt;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign inPay     = {in_tag, in_ctrl, in_data};
  assign out_valid = (state != EMPTY);

  // The skid variant decodes ready purely from the state register, so there is
  // no combinational path from out_ready back to in_ready.
  generate
    if (SKID != 0) begin : gSkid
      assign in_ready = (state != TWO);
    end else begin : gNoSkid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  assign acc    = in_valid & in_ready & hit;
  assign take   = out_valid & out_ready & hit;
  assign bubble = hit & ~flush & out_ready & ~out_valid;

  always_comb begin
    stateNext    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          stateNext  = ONE;
          loadMainIn = 1'b1;
        end
        ONE: begin
          if (acc && take) begin
            loadMainIn = 1'b1;
          end else if (acc) begin
            stateNext = TWO;
            loadSkid  = 1'b1;
          end else if (take) begin
            stateNext = EMPTY;
          end
        end
        TWO: if (take) begin
          stateNext    = ONE;
          loadMainSkid = 1'b1;
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= stateNext;
  end

  // Main slot keeps stale payload on flush; out_ctrl gating hides it.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainPay <= '0;
      skidPay <= '0;
    end else begin
      if (loadMainIn)        mainPay <= inPay;
      else if (loadMainSkid) mainPay <= skidPay;
      if (flush || loadMainSkid) skidPay <= '0;
      else if (loadSkid)         skidPay <= inPay;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)      bubbleCnt <= '0;
    else if (bubble) bubbleCnt <= satInc(bubbleCnt);
  end

  assign out_data   = mainPay[DN_W-1:0];
  assign out_ctrl   = mainPay[DN_W +: CTRL_W] & {CTRL_W{out_valid}};
  assign out_tag    = mainPay[DN_W+CTRL_W +: TAG_W];
  assign bubble_cnt = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: queue scoreboard models the stage as a
// FIFO (depth 2 with skid, depth 1 without) and checks every falling edge.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [127:0] d;
    logic [9:0]   c;
    logic [15:0]  t;
  } ent_t;

  logic         clk = 1'b1;
  logic         rst_n, hit, flush;
  logic         inValid, outReady, inValid0, outReady0;
  logic [127:0] inData, inData0;
  logic [9:0]   inCtrl, inCtrl0;
  logic [15:0]  inTag, inTag0;

  logic         inReady, outValid, inReadyS, outValidS, inReady0, outValid0;
  logic [127:0] outData, outDataS, outData0;
  logic [9:0]   outCtrl, outCtrlS, outCtrl0;
  logic [15:0]  outTag, outTagS, outTag0, bubbleCnt, bubbleCnt0;
  logic [3:0]   bubbleCntS;

  ent_t q[$], q0[$];
  int   bub, bub0;
  int   nCmp, nMis;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_ctrl(inCtrl), .in_tag(inTag),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_ctrl(outCtrl),
    .out_tag(outTag), .bubble_cnt(bubbleCnt));

  id_ex_stage_reg #(.CNT_W(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyS), .in_data(inData), .in_ctrl(inCtrl), .in_tag(inTag),
    .out_valid(outValidS), .out_ready(outReady), .out_data(outDataS), .out_ctrl(outCtrlS),
    .out_tag(outTagS), .bubble_cnt(bubbleCntS));

  id_ex_stage_reg #(.SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
    .in_valid(inValid0), .in_ready(inReady0), .in_data(inData0), .in_ctrl(inCtrl0), .in_tag(inTag0),
    .out_valid(outValid0), .out_ready(outReady0), .out_data(outData0), .out_ctrl(outCtrl0),
    .out_tag(outTag0), .bubble_cnt(bubbleCnt0));

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setIn(input logic [31:0] w0);
    inData = {$urandom, $urandom, $urandom, w0};
    inCtrl = 10'($urandom);
    inTag  = 16'($urandom);
  endtask

  task automatic checkOut();
    chk("out_valid", outValid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", outData, q[0].d);
      chk("out_ctrl", outCtrl, q[0].c);
      chk("out_tag", outTag, q[0].t);
    end else begin
      chk("out_ctrl_idle", outCtrl, 0);
    end
    chk("bubble_cnt", bubbleCnt, bub);
    chk("bubble_cnt_sat", bubbleCntS, (bub > 15) ? 15 : bub);
    chk("out_valid0", outValid0, q0.size() > 0);
    if (q0.size() > 0) begin
      chk("out_data0", outData0, q0[0].d);
      chk("out_ctrl0", outCtrl0, q0[0].c);
      chk("out_tag0", outTag0, q0[0].t);
    end else begin
      chk("out_ctrl0_idle", outCtrl0, 0);
    end
    chk("bubble_cnt0", bubbleCnt0, bub0);
  endtask

  task automatic tick();
    logic accM, takeM, acc0, take0;
    ent_t e, e0;
    #1;
    chk("in_ready", inReady, q.size() < 2);
    chk("in_ready0", inReady0, (q0.size() == 0) || outReady0);
    accM  = inValid && (q.size() < 2) && hit && !flush;
    takeM = (q.size() > 0) && outReady && hit && !flush;
    acc0  = inValid0 && ((q0.size() == 0) || outReady0) && hit && !flush;
    take0 = (q0.size() > 0) && outReady0 && hit && !flush;
    if (hit && !flush && outReady && q.size() == 0) bub++;
    if (hit && !flush && outReady0 && q0.size() == 0) bub0++;
    e  = {inData, inCtrl, inTag};
    e0 = {inData0, inCtrl0, inTag0};
    @(negedge clk);
    if (flush) begin
      q.delete();
      q0.delete();
    end else begin
      if (takeM) void'(q.pop_front());
      if (accM)  q.push_back(e);
      if (take0) void'(q0.pop_front());
      if (acc0)  q0.push_back(e0);
    end
    #1;
    checkOut();
  endtask

  // Reset is asserted between edges; outputs must clear without a clock.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    q.delete();
    q0.delete();
    bub  = 0;
    bub0 = 0;
    checkOut();
    chk("rst_in_ready", inReady, 1);
    chk("rst_in_ready0", inReady0, 1);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    nCmp = 0; nMis = 0; bub = 0; bub0 = 0;
    rst_n = 1'b0; hit = 1'b1; flush = 1'b0;
    inValid = 1'b0; outReady = 1'b0; inData = '0; inCtrl = '0; inTag = '0;
    inValid0 = 1'b0; outReady0 = 1'b0; inData0 = '0; inCtrl0 = '0; inTag0 = '0;
    #2;
    checkOut();
    chk("init_in_ready", inReady, 1);
    rst_n = 1'b1;
    #1;

    // Reset mid-stream with an all-ones control word held
    setIn(32'hAAAA);
    inCtrl  = 10'h3FF;
    inValid = 1'b1;
    tick();
    chk("loaded_ctrl", outCtrl, 10'h3FF);
    inValid = 1'b0;
    doReset();

    // Streaming, one-edge latency, 100 entries
    inValid  = 1'b1;
    outReady = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      setIn(i);
      tick();
      chk("stream_word0", outData[31:0], i);
    end
    inValid = 1'b0;
    tick();

    // Back-pressure into the skid slot, then drain
    outReady = 1'b0;
    inValid  = 1'b1;
    setIn(32'hA);
    tick();
    setIn(32'hB);
    tick();
    inValid = 1'b0;
    tick();
    chk("bp_full_ready", inReady, 0);
    chk("bp_head_A", outData[31:0], 32'hA);
    outReady = 1'b1;
    tick();
    chk("bp_head_B", outData[31:0], 32'hB);
    chk("bp_ready_back", inReady, 1);
    tick();
    chk("bp_drained", outValid, 0);

    // Freeze while full
    outReady = 1'b0;
    inValid  = 1'b1;
    setIn(32'h11);
    tick();
    setIn(32'h22);
    tick();
    setIn(32'h33);
    hit      = 1'b0;
    outReady = 1'b1;
    repeat (5) tick();
    chk("freeze_head", outData[31:0], 32'h11);
    hit     = 1'b1;
    inValid = 1'b0;
    repeat (3) tick();

    // Flush while full with an offered input
    outReady = 1'b0;
    inValid  = 1'b1;
    setIn(32'h44);
    inCtrl = 10'h208;
    tick();
    setIn(32'h55);
    tick();
    chk("pre_flush_ctrl", outCtrl, 10'h208);
    setIn(32'h66);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", outValid, 0);
    chk("flush_ctrl", outCtrl, 0);
    setIn(32'hC);
    tick();
    inValid = 1'b0;
    chk("post_flush_C", outData[31:0], 32'hC);
    outReady = 1'b1;
    repeat (2) tick();

    // Bubble saturation on the 4-bit counter
    doReset();
    outReady = 1'b1;
    inValid  = 1'b0;
    repeat (20) tick();
    chk("bubble_sat_final", bubbleCntS, 4'hF);

    // Single-entry variant under random push/pull
    outReady = 1'b0;
    for (int i = 0; i < 50; i++) begin
      inValid0  = 1'($urandom);
      outReady0 = 1'($urandom);
      inData0   = {$urandom, $urandom, $urandom, $urandom};
      inCtrl0   = 10'($urandom);
      inTag0    = 16'($urandom);
      tick();
    end
    inValid0  = 1'b0;
    outReady0 = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID→EX pipeline stage register, successor to the fixed-field ID/EX latch.
- Carries operand data, control bits and register/funct tags with a valid/ready handshake.
- Two-entry skid buffer, so upstream can be back-pressured without a combinational ready path.
- Also provides pipeline flush (branch mispredict or exception), global freeze on cache miss (hit=0), and a saturating bubble counter.

Parameters:
- DATA_W, 32, width of one data word.
- NUM_DATA, 4, number of data words carried (readData1, readData2, signExImmediate, nextPC).
- CTRL_W, 10, control-bit vector width (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[2:0]).
- TAG_W, 16, tag width (rt[4:0], rd[4:0], funct[5:0]).
- SKID, 1, 1 = two-entry skid buffer; 0 = single entry with combinational in_ready.
- CNT_W, 16, bubble counter width.

Ports:
- clk, input, 1, clock; all state updates on the falling edge, matching the other pipeline registers.
- rst_n, input, 1, asynchronous active-low reset.
- hit, input, 1, 0 = memory miss; freezes all state except reset and flush.
- flush, input, 1, squash all held and incoming entries.
- in_valid, input, 1, upstream entry valid.
- in_ready, output, 1, stage can accept an entry.
- in_data, input, DATA_W*NUM_DATA, packed data words; word 0 in the LSBs.
- in_ctrl, input, CTRL_W, control bits.
- in_tag, input, TAG_W, register/funct tags.
- out_valid, output, 1, entry presented to EX.
- out_ready, input, 1, EX accepts the entry.
- out_data, output, DATA_W*NUM_DATA, held data.
- out_ctrl, output, CTRL_W, held control bits; forced 0 when out_valid=0.
- out_tag, output, TAG_W, held tags.
- bubble_cnt, output, CNT_W, count of bubble cycles seen by EX.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ctrl=0, out_tag=0, skid slot empty and zero, bubble_cnt=0, in_ready=1. Reset takes effect immediately, including mid-transfer.
- Transfer events:
  - acc = in_valid & in_ready & hit.
  - take = out_valid & out_ready & hit.
  - Both are evaluated at the falling edge.
- State (SKID=1): EMPTY, ONE (main slot valid), TWO (main and skid valid).
  - EMPTY: acc → ONE, main <= input.
  - ONE: acc & take → ONE, main <= input. acc only → TWO, skid <= input. take only → EMPTY. Neither → hold.
  - TWO: in_ready=0, so acc is impossible. take → ONE, main <= skid. Otherwise hold.
  - in_ready is registered: in_ready = (state != TWO).
- SKID=0:
  - Single main slot; in_ready = ~out_valid | out_ready (combinational).
  - acc loads main; take without acc → empty.
- Latency: an entry accepted at edge N is on the outputs from edge N onward when the stage was EMPTY. Otherwise it appears at the edge where the preceding entry is taken.
- Ordering: strict FIFO. No entry is duplicated or dropped except by flush.
- hit=0: no slot, state or counter changes. in_ready and out_* hold their values. Upstream and downstream must keep their signals stable.
- flush=1 (overrides hit and every handshake):
  - At the edge, state → EMPTY.
  - out_valid=0, out_ctrl=0, skid cleared.
  - Any simultaneously offered input is discarded. in_ready reads 1 after the edge.
  - Data and tag registers may retain stale values, but out_ctrl must be 0 so that RegWrite and MemWrite are never asserted for a squashed entry.
  - flush together with reset: reset wins.
- Bubble counter:
  - Increments at each edge where hit=1, flush=0, out_ready=1 and out_valid=0.
  - Saturates at 2^CNT_W-1 with no wrap.
- Output gating: out_ctrl = held_ctrl & {CTRL_W{out_valid}}.
- Widths: all payload fields are passed bit-exact; no arithmetic on the payload.

Test Plan:
- Reset mid-stream: load entry with in_ctrl=10'h3FF, then pulse rst_n low between edges → outputs 0 immediately, in_ready=1, bubble_cnt=0.
- Streaming: in_valid=1, out_ready=1, hit=1, data words 1,2,3,… → out_data word 0 matches with 1-edge latency; in_ready stays 1; 100 entries, none lost.
- Back-pressure: out_ready=0, push A and B → state TWO, in_ready=0. Then out_ready=1 → A on the first edge, B on the second, in_ready=1 after A is taken.
- Freeze: state TWO, hit=0 for 5 edges with out_ready=1 → outputs unchanged and bubble_cnt unchanged. hit=1 → drain resumes in order.
- Flush: state TWO with out_ctrl=10'h208, plus in_valid=1 at the same edge as flush=1 → out_valid=0, out_ctrl=0, in_ready=1. The next accepted entry C is the next output; the flushed input never appears.
- Bubble saturation (CNT_W=4): out_ready=1, no input for 20 edges → bubble_cnt reaches 15 and holds. SKID=0 build: push/pull 50 random entries → FIFO order kept, in_ready = ~out_valid | out_ready.
